fused_systolic_array: RTL and testbench

Weight-stationary, precision-configurable systolic array built as the next generation of the fusion-unit array in the accelerator datapath. Rows and columns are parametrised. The block adds:
- a configuration/load/compute/drain state machine,
- valid/ready handshakes on every stream,
- internal input skewing and output deskewing, so callers see aligned vectors,
- full-pipeline stall on output backpressure.

It sits between the activation buffer (input stream) and the accumulator/output buffer (psum stream).

---
 rtl/fused_systolic_array.sv | 276 +++++++++++++++++++++++++++
 tb/tb_fused_systolic_array.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fused_systolic_array.sv
// Weight-stationary, precision-configurable systolic array with a config/load/compute/drain
// controller, valid/ready streams, internal skew/deskew and whole-pipeline stall on backpressure.
module fused_systolic_array #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int ACC_W = 16 + $clog2(ROWS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [1:0]              cfg_mode,
    input  logic                    cfg_s_in,
    input  logic                    cfg_s_weight,
    input  logic                    w_valid,
    output logic                    w_ready,
    input  logic [COLS*8-1:0]       w_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ROWS*8-1:0]       in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [COLS*ACC_W-1:0]   out_data,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done
);

    localparam int L     = ROWS + COLS - 1;
    localparam int CNT_W = $clog2(ROWS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [1:0]             mode_r;
    logic                   s_in_r;
    logic                   s_w_r;
    logic [CNT_W-1:0]       w_cnt_r;
    logic [7:0]             w_r     [ROWS][COLS];
    logic [7:0]             a_r     [ROWS][COLS];
    logic [ACC_W-1:0]       ps_r    [ROWS][COLS];
    logic [7:0]             a_in_s  [ROWS][COLS];
    logic [ACC_W-1:0]       ps_in_s [ROWS][COLS];
    logic [ROWS*8-1:0]      in_byte_s;
    logic [ROWS*8-1:0]      skew_out_s;
    logic [COLS*ACC_W-1:0]  col_out_s;
    logic [L-1:0]           tok_v_r;
    logic [L-1:0]           tok_l_r;
    logic                   out_valid_r;
    logic                   out_last_r;
    logic                   done_r;
    logic                   stall_s;
    logic                   adv_s;
    logic                   cfg_acc_s;
    logic                   w_acc_s;
    logic                   in_acc_s;
    logic                   out_acc_s;

    // Lane-split multiply-accumulate of one input byte against one weight byte.
    // Mode 2'b11 falls into the default (full 8b x 8b) branch.
    function automatic logic [ACC_W-1:0] pe_product(
        input logic [7:0] a,
        input logic [7:0] b,
        input logic [1:0] mode,
        input logic       sa,
        input logic       sb
    );
        logic signed [17:0]        ea;
        logic signed [17:0]        eb;
        logic signed [17:0]        sum;
        logic        [ACC_W+17:0]  wide;
        sum = 18'sd0;
        ea  = 18'sd0;
        eb  = 18'sd0;
        case (mode)
            2'b01: begin
                for (int l = 0; l < 2; l++) begin
                    ea  = {{14{sa & a[4*l+3]}}, a[4*l +: 4]};
                    eb  = {{14{sb & b[4*l+3]}}, b[4*l +: 4]};
                    sum = sum + ea * eb;
                end
            end
            2'b10: begin
                for (int l = 0; l < 4; l++) begin
                    ea  = {{16{sa & a[2*l+1]}}, a[2*l +: 2]};
                    eb  = {{16{sb & b[2*l+1]}}, b[2*l +: 2]};
                    sum = sum + ea * eb;
                end
            end
            default: begin
                ea  = {{10{sa & a[7]}}, a};
                eb  = {{10{sb & b[7]}}, b};
                sum = ea * eb;
            end
        endcase
        wide = {{ACC_W{sum[17]}}, sum};
        return wide[ACC_W-1:0];
    endfunction

    assign stall_s   = out_valid_r & ~out_ready;
    assign adv_s     = ~stall_s;
    assign cfg_acc_s = cfg_valid & (state_r == ST_IDLE);
    assign w_acc_s   = w_valid & (state_r == ST_LOAD);
    assign in_acc_s  = in_valid & (state_r == ST_COMPUTE) & adv_s;
    assign out_acc_s = out_valid_r & out_ready;
    assign in_byte_s = in_acc_s ? in_data : {(ROWS*8){1'b0}};

    assign cfg_ready = (state_r == ST_IDLE);
    assign w_ready   = (state_r == ST_LOAD);
    assign in_ready  = (state_r == ST_COMPUTE) & adv_s;
    assign busy      = (state_r != ST_IDLE);
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign out_data  = col_out_s;
    assign done      = done_r;

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; every transition rides on an accepted handshake.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cfg_acc_s) state_nxt_s = ST_LOAD;
                else           state_nxt_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (w_acc_s && (w_cnt_r == CNT_W'(ROWS - 1))) state_nxt_s = ST_COMPUTE;
                else                                          state_nxt_s = ST_LOAD;
            end
            ST_COMPUTE: begin
                if (in_acc_s && in_last) state_nxt_s = ST_DRAIN;
                else                     state_nxt_s = ST_COMPUTE;
            end
            ST_DRAIN: begin
                if (out_acc_s && out_last_r) state_nxt_s = ST_IDLE;
                else                         state_nxt_s = ST_DRAIN;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Latched job configuration, weight beat counter and the completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r  <= 2'b00;
            s_in_r  <= 1'b0;
            s_w_r   <= 1'b0;
            w_cnt_r <= {CNT_W{1'b0}};
            done_r  <= 1'b0;
        end else begin
            if (cfg_acc_s) begin
                mode_r  <= cfg_mode;
                s_in_r  <= cfg_s_in;
                s_w_r   <= cfg_s_weight;
                w_cnt_r <= {CNT_W{1'b0}};
            end else if (w_acc_s) begin
                w_cnt_r <= w_cnt_r + CNT_W'(1);
            end
            done_r <= (state_r == ST_DRAIN) & out_acc_s & out_last_r;
        end
    end

    // Weight rows shift downward; the newest beat always lands in row 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    w_r[r][c] <= 8'h00;
        end else if (w_acc_s) begin
            for (int r = ROWS - 1; r > 0; r--)
                for (int c = 0; c < COLS; c++)
                    w_r[r][c] <= w_r[r-1][c];
            for (int c = 0; c < COLS; c++)
                w_r[0][c] <= w_data[8*c +: 8];
        end
    end

    // Skew stage: row r sees its byte r cycles after acceptance.
    for (genvar r = 0; r < ROWS; r++) begin : g_skew
        if (r == 0) begin : g_pass
            assign skew_out_s[7:0] = in_byte_s[7:0];
        end else begin : g_dly
            logic [7:0] sk_r [r];
            // Per-row delay line, frozen on stall.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < r; k++) sk_r[k] <= 8'h00;
                end else if (adv_s) begin
                    sk_r[0] <= in_byte_s[8*r +: 8];
                    for (int k = 1; k < r; k++) sk_r[k] <= sk_r[k-1];
                end
            end
            assign skew_out_s[8*r +: 8] = sk_r[r-1];
        end
    end

    // Neighbour wiring: activations enter from the left, partial sums from above.
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            a_in_s[r][0] = skew_out_s[8*r +: 8];
            for (int c = 1; c < COLS; c++) a_in_s[r][c] = a_r[r][c-1];
        end
        for (int c = 0; c < COLS; c++) begin
            ps_in_s[0][c] = {ACC_W{1'b0}};
            for (int r = 1; r < ROWS; r++) ps_in_s[r][c] = ps_r[r-1][c];
        end
    end

    // PE array: register the passing activation and the accumulated column sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    a_r[r][c]  <= 8'h00;
                    ps_r[r][c] <= {ACC_W{1'b0}};
                end
        end else if (adv_s) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    a_r[r][c]  <= a_in_s[r][c];
                    ps_r[r][c] <= ps_in_s[r][c] + pe_product(a_r[r][c], w_r[r][c], mode_r, s_in_r, s_w_r);
                end
        end
    end

    // Deskew stage: column c waits COLS-1-c cycles so a whole vector leaves together.
    for (genvar c = 0; c < COLS; c++) begin : g_deskew
        if (c == COLS - 1) begin : g_pass
            assign col_out_s[c*ACC_W +: ACC_W] = ps_r[ROWS-1][c];
        end else begin : g_dly
            localparam int D = COLS - 1 - c;
            logic [ACC_W-1:0] dq_r [D];
            // Per-column delay line, frozen on stall.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < D; k++) dq_r[k] <= {ACC_W{1'b0}};
                end else if (adv_s) begin
                    dq_r[0] <= ps_r[ROWS-1][c];
                    for (int k = 1; k < D; k++) dq_r[k] <= dq_r[k-1];
                end
            end
            assign col_out_s[c*ACC_W +: ACC_W] = dq_r[D-1];
        end
    end

    // Occupancy tokens follow each vector; the final stage drives out_valid/out_last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tok_v_r     <= {L{1'b0}};
            tok_l_r     <= {L{1'b0}};
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else if (adv_s) begin
            tok_v_r     <= {tok_v_r[L-2:0], in_acc_s};
            tok_l_r     <= {tok_l_r[L-2:0], in_acc_s & in_last};
            out_valid_r <= tok_v_r[L-1];
            out_last_r  <= tok_l_r[L-1];
        end
    end

endmodule

// File: tb/tb_fused_systolic_array.sv
// Randomised and directed bench for fused_systolic_array against an integer-arithmetic reference.
module tb_fused_systolic_array;

    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int ACC_W = 16 + $clog2(ROWS);
    localparam int L     = ROWS + COLS - 1;
    localparam int DW    = COLS * ACC_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_valid, cfg_ready, cfg_s_in, cfg_s_weight;
    logic [1:0]        cfg_mode;
    logic              w_valid, w_ready;
    logic [COLS*8-1:0] w_data;
    logic              in_valid, in_ready, in_last;
    logic [ROWS*8-1:0] in_data;
    logic              out_valid, out_ready, out_last, busy, done;
    logic [DW-1:0]     out_data;

    fused_systolic_array #(.ROWS(ROWS), .COLS(COLS), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode),
        .cfg_s_in(cfg_s_in), .cfg_s_weight(cfg_s_weight),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int                n_tests = 0;
    int                n_fail  = 0;
    logic [7:0]        wrow [ROWS][COLS];
    logic [1:0]        cur_mode;
    bit                cur_sa, cur_sw;
    logic [ROWS*8-1:0] vec_q [$];
    logic [DW-1:0]     first_out;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sum of lane products for one byte pair, from plain integer lane arithmetic.
    function automatic int lane_sum(input logic [7:0] a, input logic [7:0] b,
                                    input logic [1:0] m, input bit sa, input bit sw);
        int w, n, x, y, s;
        w = (m == 2'd1) ? 4 : ((m == 2'd2) ? 2 : 8);
        n = 8 / w;
        s = 0;
        for (int l = 0; l < n; l++) begin
            x = int'(a >> (l * w)) & ((1 << w) - 1);
            y = int'(b >> (l * w)) & ((1 << w) - 1);
            if (sa && x >= (1 << (w - 1))) x -= (1 << w);
            if (sw && y >= (1 << (w - 1))) y -= (1 << w);
            s += x * y;
        end
        return s;
    endfunction

    function automatic logic [DW-1:0] model(input logic [ROWS*8-1:0] v);
        logic [DW-1:0] res;
        logic [31:0]   su;
        int            s;
        res = '0;
        for (int c = 0; c < COLS; c++) begin
            s = 0;
            for (int r = 0; r < ROWS; r++)
                s += lane_sum(v[8*r +: 8], wrow[r][c], cur_mode, cur_sa, cur_sw);
            su = s;
            res[c*ACC_W +: ACC_W] = su[ACC_W-1:0];
        end
        return res;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cfg_ready"}, cfg_ready, 1'b1);
        check({tag, "_w_ready"},   w_ready,   1'b0);
        check({tag, "_in_ready"},  in_ready,  1'b0);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_out_last"},  out_last,  1'b0);
        check({tag, "_out_data"},  out_data,  '0);
        check({tag, "_busy"},      busy,      1'b0);
        check({tag, "_done"},      done,      1'b0);
    endtask

    task automatic do_cfg(input logic [1:0] m, input bit sa, input bit sw);
        @(negedge clk);
        cfg_valid = 1'b1; cfg_mode = m; cfg_s_in = sa; cfg_s_weight = sw;
        #1;
        check("cfg_ready_idle", cfg_ready, 1'b1);
        @(negedge clk);
        cfg_valid = 1'b0;
        #1;
        check("busy_load", busy, 1'b1);
        cur_mode = m; cur_sa = sa; cur_sw = sw;
    endtask

    // Beat k carries model row ROWS-1-k so that rows end up as wrow[].
    task automatic load_w(input int nbeats);
        for (int k = 0; k < nbeats; k++) begin
            @(negedge clk);
            w_valid = 1'b1;
            for (int c = 0; c < COLS; c++) w_data[8*c +: 8] = wrow[ROWS-1-k][c];
            #1;
            check("w_ready_load", w_ready, 1'b1);
        end
        @(negedge clk);
        w_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        if (nbeats == ROWS) check("in_ready_first", in_ready, 1'b1);
    endtask

    task automatic run_job(input int rdy_mode, input int gap_mode);
        logic [DW-1:0] exp_q [$];
        logic [DW-1:0] held, e;
        int  nvec, sent, got, cyc, acc0, out0;
        bit  stalled, drain_chk;
        nvec = vec_q.size(); sent = 0; got = 0; cyc = 0; acc0 = -1; out0 = -1;
        stalled = 1'b0; drain_chk = 1'b0; held = '0;
        while (got < nvec && cyc < 3000) begin
            @(negedge clk);
            in_valid = (sent < nvec) && (gap_mode == 0 || $urandom_range(0, 3) != 0);
            in_data  = (sent < nvec) ? vec_q[sent] : '0;
            in_last  = (sent == nvec - 1);
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (stalled) begin
                check("stall_hold_data", out_data, held);
                check("stall_hold_valid", out_valid, 1'b1);
            end
            if (out_valid && out0 < 0) begin
                out0 = cyc;
                check("latency", out0 - acc0, L + 1);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", out_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e);
                    check("out_last", out_last, got == nvec - 1);
                    if (got == nvec - 1) check("done_early", done, 1'b0);
                    if (got == 0) first_out = out_data;
                    got++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(vec_q[sent]));
                if (acc0 < 0) acc0 = cyc;
                sent++;
            end else if (sent == nvec && !drain_chk) begin
                check("in_ready_drain", in_ready, 1'b0);
                drain_chk = 1'b1;
            end
            stalled = out_valid && !out_ready;
            held = out_data;
            cyc++;
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        check("job_count", got, nvec);
        @(negedge clk); #1;
        check("done_pulse", done, 1'b1);
        check("busy_idle", busy, 1'b0);
        @(negedge clk); #1;
        check("done_clear", done, 1'b0);
        vec_q.delete();
    endtask

    task automatic fill_weights(input logic [7:0] val, input bit rnd);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                wrow[r][c] = rnd ? 8'($urandom) : val;
    endtask

    task automatic push_const_vec(input logic [7:0] val);
        logic [ROWS*8-1:0] v;
        for (int r = 0; r < ROWS; r++) v[8*r +: 8] = val;
        vec_q.push_back(v);
    endtask

    task automatic push_rand_vecs(input int n);
        logic [ROWS*8-1:0] v;
        for (int i = 0; i < n; i++) begin
            for (int r = 0; r < ROWS; r++) v[8*r +: 8] = 8'($urandom);
            vec_q.push_back(v);
        end
    endtask

    function automatic logic [DW-1:0] splat(input logic [ACC_W-1:0] val);
        logic [DW-1:0] res;
        for (int c = 0; c < COLS; c++) res[c*ACC_W +: ACC_W] = val;
        return res;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ROWS*8-1:0] v;
        logic [DW-1:0]     idc;
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_mode = 2'b00; cfg_s_in = 1'b0; cfg_s_weight = 1'b0;
        w_valid = 1'b0; w_data = '0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        #12;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Identity weights, 8b unsigned: column c returns c+1.
        do_cfg(2'b00, 1'b0, 1'b0);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                wrow[r][c] = (r == c) ? 8'd1 : 8'd0;
        load_w(ROWS);
        for (int r = 0; r < ROWS; r++) v[8*r +: 8] = 8'(r + 1);
        vec_q.push_back(v);
        run_job(0, 0);
        for (int c = 0; c < COLS; c++) idc[c*ACC_W +: ACC_W] = ACC_W'(c + 1);
        check("identity", first_out, idc);

        do_cfg(2'b00, 1'b1, 1'b1);
        fill_weights(8'h80, 1'b0); load_w(ROWS);
        push_const_vec(8'h80); run_job(0, 0);
        check("signed_extreme", first_out, splat(19'h20000));

        do_cfg(2'b00, 1'b0, 1'b0);
        fill_weights(8'h80, 1'b0); load_w(ROWS);
        push_const_vec(8'h80); run_job(0, 0);
        check("unsigned_extreme", first_out, splat(19'h20000));

        do_cfg(2'b01, 1'b1, 1'b1);
        fill_weights(8'hF1, 1'b0); load_w(ROWS);
        push_const_vec(8'h23); run_job(0, 0);
        check("mode01_signed", first_out, splat(19'd8));

        do_cfg(2'b10, 1'b0, 1'b0);
        fill_weights(8'hFF, 1'b0); load_w(ROWS);
        push_const_vec(8'hFF); run_job(0, 0);
        check("mode10_unsigned", first_out, splat(19'd288));

        for (int j = 0; j < 6; j++) begin
            do_cfg(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            fill_weights(8'h00, 1'b1); load_w(ROWS);
            push_rand_vecs($urandom_range(1, 6));
            run_job(j % 3, 1);
        end

        // Back-to-back stream under a 1,0,0,1 ready pattern.
        do_cfg(2'($urandom_range(0, 2)), 1'b1, 1'b0);
        fill_weights(8'h00, 1'b1); load_w(ROWS);
        push_rand_vecs(20);
        run_job(1, 0);

        // Reset in the middle of the weight load, then a fresh job.
        do_cfg(2'b00, 1'b0, 1'b0);
        fill_weights(8'h00, 1'b1); load_w(4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midload_rst");
        @(negedge clk);
        rst_n = 1'b1;
        do_cfg(2'b01, 1'b0, 1'b1);
        fill_weights(8'h00, 1'b1); load_w(ROWS);
        push_rand_vecs(3);
        run_job(2, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
